// File: rtl/match_ctrl_pkg.sv
// Shared definitions for the match controller: state encoding, winner codes
// and the BCD digit width used by the score conversion.
package match_ctrl_pkg;

  typedef enum logic [2:0] {
    S_ATTRACT,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_CHECK,
    S_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int unsigned BCD_DIGIT_W = 4;

endpackage

// File: rtl/bcd2bin8.sv
// Combinational two-digit BCD to binary conversion (tens*10 + units).
module bcd2bin8
  import match_ctrl_pkg::*;
(
  input  logic [2*BCD_DIGIT_W-1:0] i_bcd,
  output logic [6:0]               o_bin
);

  logic [6:0] w_tens;
  logic [6:0] w_units;

  always_comb begin
    w_tens  = 7'(i_bcd[2*BCD_DIGIT_W-1:BCD_DIGIT_W]);
    w_units = 7'(i_bcd[BCD_DIGIT_W-1:0]);
    o_bin   = (w_tens << 3) + (w_tens << 1) + w_units;
  end

endmodule

// File: rtl/match_ctrl.sv
// Match sequencing for a two-player paddle game: serve pauses, point scoring
// pulses to the BCD score keepers, win detection and attract/game-over flow.
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter logic [7:0]  WIN_SCORE   = 8'h11,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned ADD_PULSE   = 4
) (
  input  logic       clk,
  input  logic       negreset,
  input  logic       frametick,
  input  logic       start,
  input  logic       missA,
  input  logic       missB,
  input  logic [7:0] scoreA,
  input  logic [7:0] scoreB,
  output logic       score_addA,
  output logic       score_addB,
  output logic       score_reset,
  output logic       ball_enable,
  output logic       serve_side,
  output logic [1:0] winner
);

  localparam int unsigned FRAME_W = $clog2(4 * HOLD_FRAMES + 1);
  localparam int unsigned PULSE_W = $clog2(ADD_PULSE + 1);
  localparam logic [6:0]  WIN_BIN = 7'(int'(WIN_SCORE[2*BCD_DIGIT_W-1:BCD_DIGIT_W]) * 10
                                       + int'(WIN_SCORE[BCD_DIGIT_W-1:0]));

  state_t               r_state, w_state_nxt;
  logic [FRAME_W-1:0]   r_frames, w_frames_nxt;
  logic [PULSE_W-1:0]   r_pulse_cnt, w_pulse_nxt;
  logic                 r_pulse_done, w_done_nxt;
  logic                 r_award, w_award_nxt;
  logic                 r_srst_hold, w_srst_hold_nxt;
  logic                 r_start_s1, r_start_s2, r_start_d;
  logic                 r_missA_d, r_missB_d;
  logic                 r_add_a, w_add_a_nxt;
  logic                 r_add_b, w_add_b_nxt;
  logic                 r_score_reset, w_srst_nxt;
  logic                 r_ball, w_ball_nxt;
  logic                 r_serve, w_serve_nxt;
  logic [1:0]           r_winner, w_winner_nxt;

  logic                 w_start_edge, w_missA_edge, w_missB_edge;
  logic [6:0]           w_a_bin, w_b_bin;

  bcd2bin8 u_bcd_a (.i_bcd(scoreA), .o_bin(w_a_bin));
  bcd2bin8 u_bcd_b (.i_bcd(scoreB), .o_bin(w_b_bin));

  assign w_start_edge = r_start_s2 & ~r_start_d;
  assign w_missA_edge = missA & ~r_missA_d;
  assign w_missB_edge = missB & ~r_missB_d;

  always_comb begin
    w_state_nxt     = r_state;
    w_frames_nxt    = r_frames;
    w_pulse_nxt     = r_pulse_cnt;
    w_done_nxt      = r_pulse_done;
    w_award_nxt     = r_award;
    w_srst_hold_nxt = 1'b0;
    w_srst_nxt      = r_srst_hold;
    w_add_a_nxt     = 1'b0;
    w_add_b_nxt     = 1'b0;
    w_ball_nxt      = 1'b0;
    w_serve_nxt     = r_serve;
    w_winner_nxt    = r_winner;
    case (r_state)
      S_ATTRACT: w_ball_nxt = 1'b1;
      S_SERVE: begin
        if (frametick) begin
          if (r_frames == FRAME_W'(HOLD_FRAMES - 1)) begin
            w_state_nxt  = S_PLAY;
            w_ball_nxt   = 1'b1;
            w_frames_nxt = '0;
          end else begin
            w_frames_nxt = r_frames + 1'b1;
          end
        end
      end
      S_PLAY: begin
        w_ball_nxt = 1'b1;
        if (w_missA_edge && w_missB_edge) begin
          w_state_nxt  = S_SERVE;
          w_ball_nxt   = 1'b0;
          w_frames_nxt = '0;
        end else if (w_missA_edge || w_missB_edge) begin
          w_state_nxt = S_POINT;
          w_ball_nxt  = 1'b0;
          w_award_nxt = w_missA_edge;
          w_add_a_nxt = w_missB_edge;
          w_add_b_nxt = w_missA_edge;
          w_pulse_nxt = '0;
          w_done_nxt  = 1'b0;
        end
      end
      S_POINT: begin
        // The pulse is raised on entry; only frameticks after it ends may advance.
        if (!r_pulse_done) begin
          if (r_pulse_cnt == PULSE_W'(ADD_PULSE - 1)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_pulse_nxt = r_pulse_cnt + 1'b1;
            w_add_a_nxt = ~r_award;
            w_add_b_nxt = r_award;
          end
        end else if (frametick) begin
          w_state_nxt = S_CHECK;
          w_serve_nxt = ~r_award;
        end
      end
      S_CHECK: begin
        w_state_nxt  = S_SERVE;
        w_frames_nxt = '0;
        if (scoreA == 8'h99 || scoreB == 8'h99) begin
          w_state_nxt  = S_OVER;
          w_winner_nxt = (w_a_bin >= w_b_bin) ? WIN_LEFT : WIN_RIGHT;
        end else if (w_a_bin >= WIN_BIN && w_a_bin >= w_b_bin + 7'd2) begin
          w_state_nxt  = S_OVER;
          w_winner_nxt = WIN_LEFT;
        end else if (w_b_bin >= WIN_BIN && w_b_bin >= w_a_bin + 7'd2) begin
          w_state_nxt  = S_OVER;
          w_winner_nxt = WIN_RIGHT;
        end
      end
      S_OVER: begin
        if (frametick) begin
          if (r_frames == FRAME_W'(4 * HOLD_FRAMES - 1)) begin
            w_state_nxt  = S_ATTRACT;
            w_ball_nxt   = 1'b1;
            w_frames_nxt = '0;
          end else begin
            w_frames_nxt = r_frames + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_ATTRACT;
    endcase
    if (w_start_edge && (r_state == S_ATTRACT || r_state == S_OVER)) begin
      w_state_nxt     = S_SERVE;
      w_frames_nxt    = '0;
      w_ball_nxt      = 1'b0;
      w_srst_nxt      = 1'b1;
      w_srst_hold_nxt = 1'b1;
      w_winner_nxt    = WIN_NONE;
      w_serve_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge negreset) begin
    if (!negreset) begin
      r_state       <= S_ATTRACT;
      r_frames      <= '0;
      r_pulse_cnt   <= '0;
      r_pulse_done  <= 1'b0;
      r_award       <= 1'b0;
      r_srst_hold   <= 1'b0;
      r_start_s1    <= 1'b0;
      r_start_s2    <= 1'b0;
      r_start_d     <= 1'b0;
      r_missA_d     <= 1'b0;
      r_missB_d     <= 1'b0;
      r_add_a       <= 1'b0;
      r_add_b       <= 1'b0;
      r_score_reset <= 1'b1;
      r_ball        <= 1'b0;
      r_serve       <= 1'b0;
      r_winner      <= WIN_NONE;
    end else begin
      r_state       <= w_state_nxt;
      r_frames      <= w_frames_nxt;
      r_pulse_cnt   <= w_pulse_nxt;
      r_pulse_done  <= w_done_nxt;
      r_award       <= w_award_nxt;
      r_srst_hold   <= w_srst_hold_nxt;
      r_start_s1    <= start;
      r_start_s2    <= r_start_s1;
      r_start_d     <= r_start_s2;
      r_missA_d     <= missA;
      r_missB_d     <= missB;
      r_add_a       <= w_add_a_nxt;
      r_add_b       <= w_add_b_nxt;
      r_score_reset <= w_srst_nxt;
      r_ball        <= w_ball_nxt;
      r_serve       <= w_serve_nxt;
      r_winner      <= w_winner_nxt;
    end
  end

  assign score_addA  = r_add_a;
  assign score_addB  = r_add_b;
  assign score_reset = r_score_reset;
  assign ball_enable = r_ball;
  assign serve_side  = r_serve;
  assign winner      = r_winner;

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: stimulus queues expected output events,
// a monitor detects output changes/pulses and matches them against the queue.
module tb_match_ctrl;
  import match_ctrl_pkg::*;

  localparam int unsigned HOLD = 60;

  logic       clk = 1'b0;
  logic       negreset = 1'b0;
  logic       frametick = 1'b0;
  logic       start = 1'b0;
  logic       missA = 1'b0;
  logic       missB = 1'b0;
  logic [7:0] scoreA = '0;
  logic [7:0] scoreB = '0;
  logic       score_addA, score_addB, score_reset, ball_enable, serve_side;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_SRST, EV_ADDA, EV_ADDB, EV_BALL, EV_SIDE, EV_WIN} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       frames;
  } ev_t;
  ev_t exp_q[$];

  match_ctrl #(
    .WIN_SCORE  (8'h11),
    .HOLD_FRAMES(HOLD),
    .ADD_PULSE  (4)
  ) dut (
    .clk        (clk),
    .negreset   (negreset),
    .frametick  (frametick),
    .start      (start),
    .missA      (missA),
    .missB      (missB),
    .scoreA     (scoreA),
    .scoreB     (scoreB),
    .score_addA (score_addA),
    .score_addB (score_addB),
    .score_reset(score_reset),
    .ball_enable(ball_enable),
    .serve_side (serve_side),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #1 frametick = 1'b1;
    @(posedge clk);
    #1 frametick = 1'b0;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic string ev_name(input ev_kind_t k);
    case (k)
      EV_SRST: return "score_reset_width";
      EV_ADDA: return "score_addA_width";
      EV_ADDB: return "score_addB_width";
      EV_BALL: return "ball_enable";
      EV_SIDE: return "serve_side";
      default: return "winner";
    endcase
  endfunction

  function automatic void expect_ev(input ev_kind_t k, input int v, input int f);
    exp_q.push_back('{kind: k, val: v, frames: f});
  endfunction

  task automatic observe(input ev_kind_t k, input int v, input int f);
    int idx = -1;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == k) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s event: got %0d, required no event", ev_name(k), v);
    end else begin
      check(ev_name(k), v, exp_q[idx].val);
      if (exp_q[idx].frames >= 0) check({ev_name(k), "_frames"}, f, exp_q[idx].frames);
      exp_q.delete(idx);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    logic       p_srst = 1'b0, p_a = 1'b0, p_b = 1'b0, p_ball = 1'b0, p_side = 1'b0;
    logic [1:0] p_win = '0;
    bit         in_srst = 0, in_a = 0, in_b = 0;
    int         w_srst = 0, w_a = 0, w_b = 0, ft = 0;
    forever begin
      @(negedge clk);
      if (!negreset) begin
        in_srst = 0; in_a = 0; in_b = 0; ft = 0;
      end else begin
        if (score_addA && score_addB) begin
          checks++;
          errors++;
          $display("FAIL add_overlap: got both score_add high, required at most one");
        end
        if (score_reset && !p_srst) begin in_srst = 1; w_srst = 0; end
        if (score_reset && in_srst) w_srst++;
        if (!score_reset && p_srst && in_srst) begin in_srst = 0; observe(EV_SRST, w_srst, -1); end
        if (score_addA && !p_a) begin in_a = 1; w_a = 0; end
        if (score_addA && in_a) w_a++;
        if (!score_addA && p_a && in_a) begin in_a = 0; observe(EV_ADDA, w_a, -1); end
        if (score_addB && !p_b) begin in_b = 1; w_b = 0; end
        if (score_addB && in_b) w_b++;
        if (!score_addB && p_b && in_b) begin in_b = 0; observe(EV_ADDB, w_b, -1); end
        if (ball_enable != p_ball) observe(EV_BALL, int'(ball_enable), ft);
        if (serve_side != p_side) observe(EV_SIDE, int'(serve_side), -1);
        if (winner != p_win) observe(EV_WIN, int'(winner), -1);
        if (ball_enable != p_ball || winner != p_win) ft = frametick ? 1 : 0;
        else if (frametick) ft++;
      end
      p_srst = score_reset; p_a = score_addA; p_b = score_addB;
      p_ball = ball_enable; p_side = serve_side; p_win = winner;
    end
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  task automatic wait_ball(input logic v, input int budget, input string name);
    int n = 0;
    while (ball_enable !== v && n < budget) begin @(negedge clk); n++; end
    check(name, int'(ball_enable), int'(v));
  endtask

  task automatic press_start();
    @(negedge clk); start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // kind 0: missB (left scores), 1: missA (right scores), 2: both (let)
  task automatic do_point(input int kind, input int side_before, input int hold);
    int n = 0;
    @(negedge clk);
    if (kind != 1) missB = 1'b1;
    if (kind != 0) missA = 1'b1;
    if (kind < 2) begin
      while (((kind == 0) ? score_addA : score_addB) !== 1'b1 && n < 40) begin
        @(negedge clk); n++;
      end
      check("add_rise", int'((kind == 0) ? score_addA : score_addB), 1);
      check("serve_side_during_pulse", int'(serve_side), side_before);
      if (kind == 0) scoreA = bcd_inc(scoreA);
      else scoreB = bcd_inc(scoreB);
    end
    repeat (hold) @(negedge clk);
    missA = 1'b0;
    missB = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_score_reset", int'(score_reset), 1);
    check("rst_ball_enable", int'(ball_enable), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_serve_side", int'(serve_side), 0);
    check("rst_score_addA", int'(score_addA), 0);
    check("rst_score_addB", int'(score_addB), 0);
    expect_ev(EV_BALL, 1, -1);
    @(posedge clk); #1 negreset = 1'b1;
    wait_ball(1'b1, 10, "attract_after_reset");

    // game 1
    expect_ev(EV_SRST, 2, -1); expect_ev(EV_BALL, 0, -1); expect_ev(EV_BALL, 1, HOLD);
    press_start();
    wait_ball(1'b1, 400, "play_after_serve");
    expect_ev(EV_BALL, 0, -1); expect_ev(EV_ADDA, 4, -1); expect_ev(EV_SIDE, 1, -1);
    expect_ev(EV_BALL, 1, -1);
    do_point(0, 0, 500);
    wait_ball(1'b1, 400, "play_after_point1");

    scoreA = 8'h10; scoreB = 8'h10;
    press_start();
    expect_ev(EV_BALL, 0, -1); expect_ev(EV_ADDA, 4, -1); expect_ev(EV_BALL, 1, -1);
    do_point(0, 1, 3);
    wait_ball(1'b1, 400, "play_after_11_10");

    expect_ev(EV_BALL, 0, -1); expect_ev(EV_BALL, 1, HOLD);
    do_point(2, 1, 3);
    wait_ball(1'b1, 400, "play_after_let");

    expect_ev(EV_BALL, 0, -1); expect_ev(EV_ADDB, 4, -1); expect_ev(EV_SIDE, 0, -1);
    expect_ev(EV_BALL, 1, -1);
    do_point(1, 1, 3);
    wait_ball(1'b1, 400, "play_after_11_11");

    scoreA = 8'h10; scoreB = 8'h05;
    expect_ev(EV_BALL, 0, -1); expect_ev(EV_ADDA, 4, -1); expect_ev(EV_SIDE, 1, -1);
    expect_ev(EV_WIN, 1, -1); expect_ev(EV_BALL, 1, 4 * HOLD);
    do_point(0, 0, 3);
    repeat (20) @(negedge clk);
    wait_ball(1'b1, 1200, "attract_after_over");
    check("winner_held_in_attract", int'(winner), 1);

    // game 2: saturation, right side higher
    expect_ev(EV_SRST, 2, -1); expect_ev(EV_WIN, 0, -1); expect_ev(EV_SIDE, 0, -1);
    expect_ev(EV_BALL, 0, -1); expect_ev(EV_BALL, 1, HOLD);
    press_start();
    wait_ball(1'b1, 400, "play_game2");
    scoreA = 8'h98; scoreB = 8'h98;
    expect_ev(EV_BALL, 0, -1); expect_ev(EV_ADDB, 4, -1); expect_ev(EV_WIN, 2, -1);
    do_point(1, 0, 3);
    repeat (40) @(negedge clk);
    expect_ev(EV_SRST, 2, -1); expect_ev(EV_WIN, 0, -1); expect_ev(EV_BALL, 1, HOLD);
    press_start();
    wait_ball(1'b1, 400, "play_after_start_in_over");

    // game 3: both saturated and equal -> left
    scoreA = 8'h98; scoreB = 8'h99;
    expect_ev(EV_BALL, 0, -1); expect_ev(EV_ADDA, 4, -1); expect_ev(EV_SIDE, 1, -1);
    expect_ev(EV_WIN, 1, -1);
    do_point(0, 0, 3);
    repeat (40) @(negedge clk);
    expect_ev(EV_SRST, 2, -1); expect_ev(EV_WIN, 0, -1); expect_ev(EV_SIDE, 0, -1);
    expect_ev(EV_BALL, 1, HOLD);
    press_start();
    wait_ball(1'b1, 400, "play_game4");

    // reset on the second clock of a score_addB pulse
    begin
      int n = 0;
      expect_ev(EV_BALL, 0, -1);
      @(negedge clk); missA = 1'b1;
      while (score_addB !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("addB_before_reset", int'(score_addB), 1);
      @(posedge clk); #1 negreset = 1'b0;
      #1;
      check("addB_cleared_by_reset", int'(score_addB), 0);
      check("addA_in_reset", int'(score_addA), 0);
      check("score_reset_in_reset", int'(score_reset), 1);
      missA = 1'b0;
      expect_ev(EV_BALL, 1, -1);
      repeat (3) @(posedge clk);
      #1 negreset = 1'b1;
      wait_ball(1'b1, 10, "attract_after_midpulse_reset");
    end
    expect_ev(EV_SRST, 2, -1); expect_ev(EV_BALL, 0, -1); expect_ev(EV_BALL, 1, HOLD);
    press_start();
    wait_ball(1'b1, 400, "play_after_final_start");

    repeat (10) @(negedge clk);
    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL missing %s event: got none, required %0d", ev_name(exp_q[i].kind), exp_q[i].val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
